mtm_alu_deserializer: RTL
=========================

MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 Parameter IDLE_TIMEOUT, 1024: max clk cycles between frames inside a packet before the partial packet is abandoned.
REQ-002 clk  input  1  posedge-active clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sin  input  1  serial input; idle level 1.
REQ-005 out_a  output  32  operand A.
REQ-006 out_b  output  32  operand B.
REQ-007 out_op  output  3  operation code (operation_t).
REQ-008 out_err  output  3  {err_data, err_crc, err_op}, one-hot or zero.
REQ-009 out_valid  output  1  result/error word available.
REQ-010 out_ready  input  1  downstream accepts word when out_valid && out_ready at posedge.
REQ-011 overflow  output  1  sticky; packet completed while previous word unaccepted.

Function
REQ-012 SHALL sample sin once per posedge clk, one bit per cycle.
REQ-013 SHALL detect a frame start on sin==0 while in IDLE or GAP; frame = start(0), ctl, d[7:0] MSB first, stop(1): 11 bits.
REQ-014 SHALL run states IDLE -> FRAME (bit counter 0..10) -> GAP (within packet) -> FRAME ... -> DONE -> IDLE.
REQ-015 Packet = data frames (ctl=0): B[31:24..7:0], then A[31:24..7:0]; then one command frame (ctl=1) with d = {0, OP[2:0], CRC[3:0]}.
REQ-016 SHALL set err_data when the command frame follows fewer or more than 8 data frames, or any stop bit samples 0; remaining frames are still received and the error is reported at the command frame.
REQ-017 SHALL compute CRC4 (x^4+x+1, init 0) over the 68-bit vector {B, A, 1'b1, OP}, first bit = MSB; mismatch sets err_crc.
REQ-018 SHALL set err_op when OP is not one of 000, 001, 100, 101.
REQ-019 Error priority: err_data > err_crc > err_op; only the highest is reported.
REQ-020 SHALL assert out_valid on the cycle after the command frame stop bit is sampled (latency 1).
REQ-021 out_a/out_b/out_op SHALL hold the received values while out_valid; they are don't-care when out_err != 0.
REQ-022 out_valid SHALL stay high with stable outputs until out_valid && out_ready; it SHALL drop the next cycle unless a new word is loaded.
REQ-023 Packet completing while out_valid && !out_ready: new word dropped, overflow set, existing word unchanged.
REQ-024 Completion in the same cycle as acceptance: the new word is loaded and out_valid stays high.
REQ-025 In GAP, IDLE_TIMEOUT cycles without a start bit: discard the partial packet silently and return to IDLE.
REQ-026 The receiver SHALL be ready for a new start bit on the cycle after any stop bit.

Reset
REQ-027 rst_n low: state IDLE, counters 0, out_a/out_b 0, out_op 000, out_err 000, out_valid 0, overflow 0; takes effect immediately regardless of clk.
REQ-028 Reset mid-packet SHALL discard all partial data; the first start bit after release begins a new packet.

Configuration
REQ-029 Macro MTM_RX_CRC_CHECK_EN defined: CRC check per REQ-017.
REQ-030 Macro undefined: CRC field ignored, err_crc never set, no CRC logic synthesised.

Structure
REQ-031 Package mtm_alu_pkg SHALL hold: operation_t enum, frame length constant (11), data frame count (8), the CRC4 68-bit next-state function.
REQ-032 Sub-module mtm_alu_rx_frame SHALL receive one 11-bit frame and output {ctl, data, stop_ok, frame_done}; the top level holds packet assembly, checks and output handshake.

Verification
REQ-033 B=0x00000014, A=0x00000013, OP=100, correct CRC, out_ready=1 -> one out_valid pulse, out_a=19, out_b=20, out_op=100, out_err=000.
REQ-034 Same packet with CRC bit 0 inverted -> out_err=010 (macro defined); out_err=000 (macro undefined).
REQ-035 7 data frames, then a command frame -> out_err=100; next correct packet reports out_err=000.
REQ-036 OP=010, correct CRC -> out_err=001; OP=111 with wrong CRC -> out_err=010.
REQ-037 out_ready=0, two correct packets (second A=0xFFFFFFFF) -> first word held, overflow=1; ready=1 -> first word accepted, out_valid drops.
REQ-038 rst_n low after 4 data frames, then a full correct packet -> only the second packet is reported; 5 frames then 1100 idle cycles, then a full packet -> only the full packet is reported, out_err=000.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared types, frame constants and CRC4 helper for the MTM ALU serial receiver
package mtm_alu_pkg;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;
  localparam int FRAME_LEN   = 11;
  localparam int DATA_FRAMES = 8;
  // x^4+x+1, MSB of d shifted in first
  function automatic logic [3:0] crc4_next(input logic [67:0] d, input logic [3:0] c);
    logic [3:0] r;
    r = c;
    for (int i = 67; i >= 0; i--) r = {r[2:0], 1'b0} ^ ({4{r[3] ^ d[i]}} & 4'b0011);
    return r;
  endfunction
endpackage

// File: rtl/mtm_alu_rx_frame.sv
// mtm_alu_rx_frame: receives one 11-bit frame (start, ctl, d[7:0] MSB first, stop)
module mtm_alu_rx_frame
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       busy,
  output logic       ctl,
  output logic [7:0] data,
  output logic       stop_ok,
  output logic       frame_done
);
  logic [3:0] cnt;
  logic [8:0] sh;
  // frame_done and stop_ok are combinational so the packet layer reacts on the stop-bit edge itself
  assign frame_done = busy && cnt == 4'(FRAME_LEN - 1);
  assign stop_ok    = sin;
  assign ctl        = sh[8];
  assign data       = sh[7:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
    end else if (!busy) begin
      busy <= !sin;
      cnt  <= sin ? 4'd0 : 4'd1;
    end else if (frame_done) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else begin
      sh  <= {sh[7:0], sin};
      cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: assembles serial frames into ALU operand/op words with error checks
// and a valid/ready output; define MTM_RX_CRC_CHECK_EN to enable the CRC4 check.
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);
  localparam int GW = $clog2(IDLE_TIMEOUT + 1);
  logic          busy, ctl, stop_ok, frame_done;
  logic [7:0]    data;
  logic [63:0]   pkt;
  logic [3:0]    dcnt;
  logic          bad_stop, in_pkt;
  logic [GW-1:0] gap;
  logic          cmd, load, timeout, e_data, e_crc, e_op;
  logic [2:0]    err;
  mtm_alu_rx_frame u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .busy      (busy),
    .ctl       (ctl),
    .data      (data),
    .stop_ok   (stop_ok),
    .frame_done(frame_done)
  );
  assign cmd     = frame_done && ctl;
  assign load    = cmd && (!out_valid || out_ready);
  assign timeout = in_pkt && !busy && sin && gap == GW'(IDLE_TIMEOUT - 1);
  assign e_data  = bad_stop || !stop_ok || dcnt != 4'(DATA_FRAMES);
`ifdef MTM_RX_CRC_CHECK_EN
  assign e_crc   = crc4_next({pkt, 1'b1, data[6:4]}, 4'h0) != data[3:0];
`else
  assign e_crc   = 1'b0;
`endif
  assign e_op    = !(data[6:4] inside {OP_AND, OP_OR, OP_ADD, OP_SUB});
  assign err     = e_data ? 3'b100 : e_crc ? 3'b010 : e_op ? 3'b001 : 3'b000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pkt       <= '0;
      dcnt      <= '0;
      bad_stop  <= 1'b0;
      in_pkt    <= 1'b0;
      gap       <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_err   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (frame_done && !ctl) begin
        pkt      <= {pkt[55:0], data};
        dcnt     <= dcnt == 4'hf ? dcnt : dcnt + 4'd1;
        bad_stop <= bad_stop | ~stop_ok;
        in_pkt   <= 1'b1;
        gap      <= '0;
      end else if (cmd || timeout) begin
        dcnt     <= '0;
        bad_stop <= 1'b0;
        in_pkt   <= 1'b0;
        gap      <= '0;
      end else if (in_pkt && !busy && sin) begin
        gap <= gap + 1'b1;
      end
      if (load) begin
        out_b     <= pkt[63:32];
        out_a     <= pkt[31:0];
        out_op    <= data[6:4];
        out_err   <= err;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (cmd && !load) overflow <= 1'b1;
    end
endmodule
